// File: rtl/decap_seq_pkg.sv
// Shared types and helpers for the decap bank sequencer.
package decap_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  // Bits needed to hold a segment count in 0..nseg.
  function automatic int level_w(input int nseg);
    return $clog2(nseg + 1);
  endfunction

  // Bit idx of the thermometer code for lvl enabled segments.
  function automatic logic therm_bit(input int lvl, input int idx);
    return (lvl > idx);
  endfunction

endpackage

// File: rtl/decap_seq_dwell_timer.sv
// Dwell down-counter: load has priority over decrement, clear over load; stops at zero.
module decap_seq_dwell_timer
  import decap_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decap_bank_sequencer.sv
// Steps a thermometer-coded decap bank one segment per dwell toward the level request.
// Optional DECAP_SEQ_FORCE_OFF_EN adds FORCE_OFF, an immediate drop-all below RST priority.
module decap_bank_sequencer
  import decap_seq_pkg::*;
#(
  parameter int NSEG    = 16,
  parameter int DWELL_W = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ,
  input  logic [DWELL_W-1:0]          DWELL,
`ifdef DECAP_SEQ_FORCE_OFF_EN
  input  logic                        FORCE_OFF,
`endif
  output logic [NSEG-1:0]             EN,
  output logic [level_w(NSEG)-1:0]    LEVEL,
  output logic                        BUSY,
  output logic                        ACK
);

  localparam int LW = level_w(NSEG);

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [NSEG-1:0] en_q, en_d;
  logic            tmr_load, tmr_dec, tmr_clr, tmr_zero;

  decap_seq_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (DWELL),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (REQ) begin
          level_d  = LW'(1);
          tmr_load = 1'b1;
          state_d  = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (!REQ) begin
          tmr_load = 1'b1;
          state_d  = ST_RAMP_DOWN;
        end else if (level_q < LW'(NSEG)) begin
          level_d  = level_q + LW'(1);
          tmr_load = 1'b1;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!REQ) begin
          level_d  = LW'(NSEG - 1);
          tmr_load = 1'b1;
          state_d  = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (REQ) begin
          tmr_load = 1'b1;
          state_d  = ST_RAMP_UP;
        end else if (level_q != '0) begin
          level_d  = level_q - LW'(1);
          tmr_load = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
`ifdef DECAP_SEQ_FORCE_OFF_EN
    if (FORCE_OFF) begin
      state_d  = ST_OFF;
      level_d  = '0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_clr  = 1'b1;
    end
`endif
  end

  // EN is decoded from the next level so both registers always agree.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NSEG; i++) begin
      en_d[i] = therm_bit(int'(level_d), i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      level_q <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      en_q    <= en_d;
    end
  end

  assign EN    = en_q;
  assign LEVEL = level_q;
  assign BUSY  = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign ACK   = ((state_q == ST_OFF) && !REQ) || ((state_q == ST_ON) && REQ);

endmodule

// File: tb/tb_decap_bank_sequencer.sv
// Directed bench for decap_bank_sequencer (NSEG=4, DWELL_W=4) with a per-cycle reference model.
module tb_decap_bank_sequencer;

  localparam int NSEG    = 4;
  localparam int DWELL_W = 4;

  logic               CLK;
  logic               RST;
  logic               REQ;
  logic [DWELL_W-1:0] DWELL;
  logic [NSEG-1:0]    EN;
  logic [2:0]         LEVEL;
  logic               BUSY;
  logic               ACK;
  logic               fo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

`ifdef DECAP_SEQ_FORCE_OFF_EN
  logic force_off;
  assign fo = force_off;
`else
  assign fo = 1'b0;
`endif

  decap_bank_sequencer #(.NSEG(NSEG), .DWELL_W(DWELL_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .DWELL     (DWELL),
`ifdef DECAP_SEQ_FORCE_OFF_EN
    .FORCE_OFF (force_off),
`endif
    .EN        (EN),
    .LEVEL     (LEVEL),
    .BUSY      (BUSY),
    .ACK       (ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bank moving one segment per dwell toward the requested end.
  // m_dir: +1 climbing, -1 falling, 0 settled (m_on says which end).
  int m_level = 0;
  int m_wait  = 0;
  int m_dir   = 0;
  bit m_on    = 0;

  task automatic model_step();
    int want;
    if (RST || fo) begin
      m_level = 0; m_wait = 0; m_dir = 0; m_on = 0;
    end else if (m_dir == 0) begin
      if (REQ != m_on) begin
        m_dir   = REQ ? 1 : -1;
        m_level = m_level + m_dir;
        m_wait  = int'(DWELL);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      want = REQ ? 1 : -1;
      if (want != m_dir) begin
        m_dir  = want;
        m_wait = int'(DWELL);
      end else if (m_level == ((m_dir > 0) ? NSEG : 0)) begin
        m_on  = (m_dir > 0);
        m_dir = 0;
      end else begin
        m_level = m_level + m_dir;
        m_wait  = int'(DWELL);
      end
    end
  endtask

  always begin
    logic [31:0] exp_en;
    @(posedge CLK);
    model_step();
    #1;
    if (chk_en) begin
      exp_en = (32'd1 << m_level) - 32'd1;
      chk("cyc_en", 32'(EN), exp_en);
      chk("cyc_level", 32'(LEVEL), 32'(m_level));
      chk("cyc_busy", 32'(BUSY), 32'(m_dir != 0));
      chk("cyc_ack", 32'(ACK), 32'((m_dir == 0) && (m_on == REQ)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    while (!ACK && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(ACK), 32'd1);
  endtask

  logic [3:0] up_tab [0:3];
  logic [3:0] dn_tab [0:3];

  initial begin
    up_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    dn_tab = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    RST = 1'b1; REQ = 1'b0; DWELL = '0;
`ifdef DECAP_SEQ_FORCE_OFF_EN
    force_off = 1'b0;
`endif
    tick(); tick();
    RST = 1'b0;
    chk("rst_en", 32'(EN), 32'h0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd1);
    chk_en = 1;

    // Ramp up with DWELL=2: step every 3 edges, settle at edge 12.
    DWELL = 4'd2; REQ = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      chk("up_en", 32'(EN), 32'(up_tab[(e / 3 > 3) ? 3 : e / 3]));
      chk("up_busy", 32'(BUSY), 32'(e < 12));
      chk("up_ack", 32'(ACK), 32'(e >= 12));
    end

    // Ramp down with DWELL=0: one segment per edge, then OFF.
    DWELL = 4'd0; REQ = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("dn_en", 32'(EN), 32'(dn_tab[e]));
      chk("dn_ack", 32'(ACK), 32'd0);
    end
    tick();
    chk("dn_off_ack", 32'(ACK), 32'd1);
    chk("dn_off_busy", 32'(BUSY), 32'd0);

    // Reversal: REQ drops mid-dwell at LEVEL=2.
    DWELL = 4'd3; REQ = 1'b1;
    for (int e = 0; e <= 5; e++) tick();
    chk("rev_lvl_start", 32'(LEVEL), 32'd2);
    REQ = 1'b0;
    for (int e = 6; e <= 20; e++) begin
      tick();
      chk("rev_level", 32'(LEVEL), (e < 12) ? 32'd2 : (e < 16) ? 32'd1 : 32'd0);
    end
    chk("rev_ack", 32'(ACK), 32'd1);

    // Reset mid-ramp at LEVEL=3.
    DWELL = 4'd1; REQ = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    chk("mid_lvl3", 32'(LEVEL), 32'd3);
    RST = 1'b1;
    tick();
    chk("mid_rst_en", 32'(EN), 32'h0);
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0; REQ = 1'b0;
    tick();
    chk("mid_rst_ack", 32'(ACK), 32'd1);

    // Mixed pattern: REQ toggles against varying dwell; the model checks every cycle.
    for (int i = 0; i < 120; i++) begin
      if (i % 9 == 0) REQ = ~REQ;
      DWELL = DWELL_W'(i % 3);
      tick();
    end
    REQ = 1'b0;
    wait_ack("mix_settle_ack", 200);

`ifdef DECAP_SEQ_FORCE_OFF_EN
    DWELL = 4'd0; REQ = 1'b1;
    wait_ack("fo_on_ack", 50);
    force_off = 1'b1;
    tick();
    chk("fo_en", 32'(EN), 32'h0);
    tick();
    chk("fo_hold_level", 32'(LEVEL), 32'd0);
    force_off = 1'b0;
    tick();
    chk("fo_restart_en", 32'(EN), 32'h1);
    REQ = 1'b0;
    wait_ack("fo_off_ack", 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
